// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial sequence detector.
package seq_det_pkg;

  localparam int OVL_OFF = 0;
  localparam int OVL_ON  = 1;

  // Width needed to hold a fill count in the range 0..pat_w.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-sequence detector with loadable pattern, overlap mode,
// input qualification and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seq,
  input  logic             seq_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             clr_cnt,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = fill_w(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] pat_q;
  logic [FW-1:0]    fill_q, fill_d;
  logic             dout_q;
  logic             match;

  always_comb begin
    hist_d = {hist_q[PAT_W-2:0], seq};
    fill_d = (fill_q == FW'(PAT_W)) ? fill_q : fill_q + 1'b1;
    match  = seq_valid && !pat_load && (fill_d == FW'(PAT_W)) && (hist_d == pat_q);
  end

  // A pattern load restarts detection so stale history cannot match the new pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PATTERN;
      dout_q <= 1'b0;
    end else if (pat_load) begin
      pat_q  <= pat_in;
      fill_q <= '0;
      dout_q <= 1'b0;
    end else if (seq_valid) begin
      hist_q <= hist_d;
      dout_q <= match;
      fill_q <= (match && (OVERLAP == OVL_OFF)) ? '0 : fill_d;
    end else begin
      dout_q <= 1'b0;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(match),
    .clr(clr_cnt),
    .q  (match_cnt)
  );

  assign dout = dout_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: overlap, non-overlap and narrow-counter detector instances on shared stimulus.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       seq = 1'b0;
  logic       seq_valid = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       clr_cnt = 1'b0;

  logic       dout_a, dout_b, dout_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .seq(seq), .seq_valid(seq_valid), .pat_load(pat_load),
    .pat_in(pat_in), .clr_cnt(clr_cnt), .dout(dout_a), .match_cnt(cnt_a));

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .seq(seq), .seq_valid(seq_valid), .pat_load(pat_load),
    .pat_in(pat_in), .clr_cnt(clr_cnt), .dout(dout_b), .match_cnt(cnt_b));

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .seq(seq), .seq_valid(seq_valid), .pat_load(pat_load),
    .pat_in(pat_in), .clr_cnt(clr_cnt), .dout(dout_c), .match_cnt(cnt_c));

  typedef struct {
    logic       r;
    logic       v;
    logic       s;
    logic       l;
    logic [3:0] p;
    logic       c;
    logic       ed;
    logic [7:0] ec;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic v, input logic s, input logic l,
                     input logic [3:0] p, input logic c, input logic ed, input logic [7:0] ec);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.l = l; t.p = p; t.c = c; t.ed = ed; t.ec = ec;
    vq.push_back(t);
  endtask

  task automatic apply(input logic r, input logic v, input logic s, input logic l,
                       input logic [3:0] p, input logic c);
    rst = r; seq_valid = v; seq = s; pat_load = l; pat_in = p; clr_cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic s);
    apply(1'b0, 1'b1, s, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [3:0] b16;
    #1;
    chk("reset dout_a", {31'd0, dout_a}, 32'd0);
    chk("reset cnt_a", {24'd0, cnt_a}, 32'd0);
    chk("reset cnt_c", {30'd0, cnt_c}, 32'd0);

    // overlap stream 1,0,1,1,0,1,1 then counter clear
    add(1,0,0,0,4'h0,0, 0,0);
    add(0,1,1,0,4'h0,0, 0,0);
    add(0,1,0,0,4'h0,0, 0,0);
    add(0,1,1,0,4'h0,0, 0,0);
    add(0,1,1,0,4'h0,0, 1,1);
    add(0,1,0,0,4'h0,0, 0,1);
    add(0,1,1,0,4'h0,0, 0,1);
    add(0,1,1,0,4'h0,0, 1,2);
    add(0,0,0,0,4'h0,0, 0,2);
    add(0,0,0,0,4'h0,1, 0,0);
    // valid gaps with seq toggling while unqualified
    add(1,0,0,0,4'h0,0, 0,0);
    add(0,1,1,0,4'h0,0, 0,0);
    for (int k = 0; k < 3; k++) add(0,0,0,0,4'h0,0, 0,0);
    add(0,1,0,0,4'h0,0, 0,0);
    for (int k = 0; k < 3; k++) add(0,0,1,0,4'h0,0, 0,0);
    add(0,1,1,0,4'h0,0, 0,0);
    for (int k = 0; k < 3; k++) add(0,0,0,0,4'h0,0, 0,0);
    add(0,1,1,0,4'h0,0, 1,1);
    add(0,0,1,0,4'h0,0, 0,1);
    // reset mid-stream discards history
    add(1,0,0,0,4'h0,0, 0,0);
    add(0,1,1,0,4'h0,0, 0,0);
    add(0,1,0,0,4'h0,0, 0,0);
    add(0,1,1,0,4'h0,0, 0,0);
    add(1,0,0,0,4'h0,0, 0,0);
    add(0,1,1,0,4'h0,0, 0,0);
    // load 0000 with a valid bit that must be ignored
    add(1,0,0,0,4'h0,0, 0,0);
    add(0,1,0,1,4'h0,0, 0,0);
    add(0,1,0,0,4'h0,0, 0,0);
    add(0,1,0,0,4'h0,0, 0,0);
    add(0,1,0,0,4'h0,0, 0,0);
    add(0,1,0,0,4'h0,0, 1,1);
    add(0,1,0,0,4'h0,0, 1,2);
    add(0,0,0,0,4'h0,0, 0,2);
    // load after partial prefix discards history
    add(1,0,0,0,4'h0,0, 0,0);
    add(0,1,1,0,4'h0,0, 0,0);
    add(0,1,0,0,4'h0,0, 0,0);
    add(0,1,1,0,4'h0,0, 0,0);
    add(0,0,0,1,4'hB,0, 0,0);
    add(0,1,1,0,4'h0,0, 0,0);
    add(0,1,1,0,4'h0,0, 0,0);
    add(0,1,0,0,4'h0,0, 0,0);
    add(0,1,1,0,4'h0,0, 0,0);
    add(0,1,1,0,4'h0,0, 1,1);

    foreach (vq[i]) begin
      apply(vq[i].r, vq[i].v, vq[i].s, vq[i].l, vq[i].p, vq[i].c);
      chk($sformatf("vec%0d dout", i), {31'd0, dout_a}, {31'd0, vq[i].ed});
      chk($sformatf("vec%0d cnt", i), {24'd0, cnt_a}, {24'd0, vq[i].ec});
    end

    // non-overlap: same stream yields a single pulse
    apply(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    chk("novl reset cnt", {24'd0, cnt_b}, 32'd0);
    bit_in(1); bit_in(0); bit_in(1);
    chk("novl pre dout", {31'd0, dout_b}, 32'd0);
    bit_in(1);
    chk("novl 4th dout", {31'd0, dout_b}, 32'd1);
    chk("novl 4th cnt", {24'd0, cnt_b}, 32'd1);
    bit_in(0); bit_in(1);
    chk("novl 6th dout", {31'd0, dout_b}, 32'd0);
    bit_in(1);
    chk("novl 7th dout", {31'd0, dout_b}, 32'd0);
    chk("novl end cnt", {24'd0, cnt_b}, 32'd1);

    // narrow counter saturates at 3, then clear beats a simultaneous match
    apply(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    b16 = 4'b1011;
    for (int j = 3; j >= 0; j--) bit_in(b16[j]);
    chk("sat m1 cnt", {30'd0, cnt_c}, 32'd1);
    for (int m = 2; m <= 5; m++) begin
      bit_in(0); bit_in(1); bit_in(1);
      chk($sformatf("sat m%0d dout", m), {31'd0, dout_c}, 32'd1);
      chk($sformatf("sat m%0d cnt", m), {30'd0, cnt_c}, (m >= 3) ? 32'd3 : 32'd2);
    end
    bit_in(0); bit_in(1);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    chk("clr+match dout", {31'd0, dout_c}, 32'd1);
    chk("clr+match cnt", {30'd0, cnt_c}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
